// File: rtl/load_store_unit.sv
// RV32I load/store front end for a word-only data memory.
// Loads and SW finish in one cycle; SB/SH do a registered read-modify-write over two cycles.
module load_store_unit #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_load,
    input  logic        in_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_address,
    input  logic [31:0] in_store_data,
    output logic [31:0] out_load_data,
    output logic        out_stall,
    output logic        out_done,
    output logic        out_fault,
    output logic [31:0] out_mem_address,
    output logic [31:0] out_mem_write_data,
    output logic        out_mem_write_enable,
    input  logic [31:0] in_mem_read_data
);

    typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] merged_q, merged_d;
    logic [31:0] addr_q, addr_d;

    logic [31:0] word_idx;
    logic [1:0]  lane;
    logic        is_byte, is_half, is_word;
    logic        f3_legal, misaligned, out_of_range, req_fault;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext, merged_word;

    assign word_idx = {2'b00, in_address[31:2]};
    assign lane     = in_address[1:0];
    assign is_byte  = (in_funct3[1:0] == 2'b00);
    assign is_half  = (in_funct3[1:0] == 2'b01);
    assign is_word  = (in_funct3[1:0] == 2'b10);

    always_comb begin
        f3_legal     = in_load ? (in_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                               : (in_funct3 inside {3'b000, 3'b001, 3'b010});
        misaligned   = (is_half && in_address[0]) || (is_word && (lane != 2'b00));
        out_of_range = (word_idx >= 32'(MEM_WORDS));
        req_fault    = !(in_load ^ in_store) || !f3_legal || misaligned || out_of_range;
    end

    // Load lane extraction and extension.
    always_comb begin
        ld_byte = in_mem_read_data[{lane, 3'b000} +: 8];
        ld_half = in_address[1] ? in_mem_read_data[31:16] : in_mem_read_data[15:0];
        case (in_funct3)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_ext = in_mem_read_data;
            3'b100:  ld_ext = {24'b0, ld_byte};
            3'b101:  ld_ext = {16'b0, ld_half};
            default: ld_ext = 32'b0;
        endcase
    end

    always_comb begin
        merged_word = in_mem_read_data;
        if (is_byte) merged_word[{lane, 3'b000} +: 8] = in_store_data[7:0];
        else         merged_word[{in_address[1], 4'b0000} +: 16] = in_store_data[15:0];
    end

    always_comb begin
        state_d              = state_q;
        merged_d             = merged_q;
        addr_d               = addr_q;
        out_load_data        = 32'b0;
        out_stall            = 1'b0;
        out_done             = 1'b0;
        out_fault            = 1'b0;
        out_mem_address      = 32'b0;
        out_mem_write_data   = 32'b0;
        out_mem_write_enable = 1'b0;
        // Outputs are held at their reset values while reset is asserted.
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (req_fault) begin
                            out_fault = 1'b1;
                        end else begin
                            out_mem_address = word_idx;
                            if (in_load) begin
                                out_load_data = ld_ext;
                                out_done      = 1'b1;
                            end else if (is_word) begin
                                out_mem_write_data   = in_store_data;
                                out_mem_write_enable = 1'b1;
                                out_done             = 1'b1;
                            end else begin
                                out_stall = 1'b1;
                                merged_d  = merged_word;
                                addr_d    = word_idx;
                                state_d   = WRITE;
                            end
                        end
                    end
                end
                WRITE: begin
                    out_mem_address      = addr_q;
                    out_mem_write_data   = merged_q;
                    out_mem_write_enable = 1'b1;
                    out_done             = 1'b1;
                    state_d              = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            merged_q <= 32'b0;
            addr_q   <= 32'b0;
        end else begin
            state_q  <= state_d;
            merged_q <= merged_d;
            addr_q   <= addr_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: a word memory model drives the DUT, and a
// byte-level reference computes the expected outputs of every cycle.
module tb_load_store_unit;

    localparam int MW = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_load, in_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_address, in_store_data;
    logic [31:0] out_load_data;
    logic        out_stall, out_done, out_fault;
    logic [31:0] out_mem_address, out_mem_write_data;
    logic        out_mem_write_enable;
    logic [31:0] in_mem_read_data;

    load_store_unit #(.MEM_WORDS(MW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_load(in_load), .in_store(in_store),
        .in_funct3(in_funct3), .in_address(in_address), .in_store_data(in_store_data),
        .out_load_data(out_load_data), .out_stall(out_stall), .out_done(out_done),
        .out_fault(out_fault), .out_mem_address(out_mem_address),
        .out_mem_write_data(out_mem_write_data),
        .out_mem_write_enable(out_mem_write_enable),
        .in_mem_read_data(in_mem_read_data)
    );

    always #5 clk = ~clk;

    // Attached memory: combinational read, write at the edge, plus a backdoor load port.
    logic [31:0] mem [0:MW-1];
    logic        bd_en = 1'b0;
    logic [5:0]  bd_idx = 6'd0;
    logic [31:0] bd_val = 32'd0;

    assign in_mem_read_data = (out_mem_address < 32'(MW)) ? mem[out_mem_address[5:0]] : 32'h0;

    always @(posedge clk) begin
        if (out_mem_write_enable && out_mem_address < 32'(MW))
            mem[out_mem_address[5:0]] <= out_mem_write_data;
        if (bd_en) mem[bd_idx] <= bd_val;
    end

    logic [31:0] ref_mem [0:MW-1];

    logic        e_stall = 0, e_done = 0, e_fault = 0, e_we = 0;
    logic [31:0] e_ld = 0, e_addr = 0, e_wd = 0;
    bit          e_addr_chk = 1, e_wd_chk = 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("stall", 32'(out_stall), 32'(e_stall));
        chk("done",  32'(out_done),  32'(e_done));
        chk("fault", 32'(out_fault), 32'(e_fault));
        chk("we",    32'(out_mem_write_enable), 32'(e_we));
        chk("load_data", out_load_data, e_ld);
        if (e_addr_chk) chk("mem_address", out_mem_address, e_addr);
        if (e_wd_chk)   chk("mem_write_data", out_mem_write_data, e_wd);
    end

    task automatic clear_exp();
        e_stall = 0; e_done = 0; e_fault = 0; e_we = 0;
        e_ld = 0; e_addr = 0; e_wd = 0; e_addr_chk = 1; e_wd_chk = 1;
    endtask

    function automatic bit legal(input bit ld, input bit st, input logic [2:0] f3,
                                 input logic [31:0] a);
        int nb;
        if (ld == st) return 0;
        if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
        if (st && !(f3 inside {3'd0, 3'd1, 3'd2})) return 0;
        nb = 1 << f3[1:0];
        if ((a % nb) != 0) return 0;
        return (a / 4) < MW;
    endfunction

    // One request from IDLE; obs returns the DUT's load data seen in the request cycle.
    task automatic do_req(input bit v, input bit ld, input bit st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d, input bit rst_mid,
                          output logic [31:0] obs);
        int nb, sh, idx;
        bit ok;
        logic [31:0] w, val, nw, mask;
        in_valid = v; in_load = ld; in_store = st; in_funct3 = f3;
        in_address = a; in_store_data = d;
        clear_exp();
        ok  = v && legal(ld, st, f3, a);
        idx = int'(a / 4);
        nb  = 1 << f3[1:0];
        sh  = 8 * int'(a % 4);
        w   = ok ? ref_mem[idx] : 32'h0;
        if (v && !ok) begin
            e_fault = 1; e_addr_chk = 0; e_wd_chk = 0;
        end else if (ok) begin
            e_addr = 32'(idx); e_wd_chk = 0;
            if (ld) begin
                val = w >> sh;
                if (nb == 1) begin
                    val = val & 32'hFF;
                    if (f3 == 3'd0 && val >= 32'h80) val = val | 32'hFFFF_FF00;
                end else if (nb == 2) begin
                    val = val & 32'hFFFF;
                    if (f3 == 3'd1 && val >= 32'h8000) val = val | 32'hFFFF_0000;
                end
                e_ld = val; e_done = 1;
            end else if (nb == 4) begin
                e_we = 1; e_done = 1; e_wd = d; e_wd_chk = 1;
            end else begin
                e_stall = 1;
            end
        end
        @(negedge clk);
        obs = out_load_data;
        @(posedge clk); #1;
        if (ok && st) begin
            if (nb == 4) begin
                ref_mem[idx] = d;
            end else begin
                mask = (nb == 1) ? 32'hFF : 32'hFFFF;
                nw = (w & ~(mask << sh)) | ((d & mask) << sh);
                clear_exp();
                if (rst_mid) begin
                    reset = 1'b1;
                end else begin
                    e_addr = 32'(idx); e_wd = nw; e_we = 1; e_done = 1;
                    in_valid = 1'($urandom); in_load = 1'($urandom); in_store = 1'($urandom);
                    in_funct3 = 3'($urandom); in_address = $urandom; in_store_data = $urandom;
                end
                @(posedge clk); #1;
                if (rst_mid) reset = 1'b0;
                else         ref_mem[idx] = nw;
            end
        end
    endtask

    task automatic setw(input int idx, input logic [31:0] val);
        logic [31:0] dummy;
        bd_en = 1'b1; bd_idx = 6'(idx); bd_val = val;
        ref_mem[idx] = val;
        do_req(0, 0, 0, 3'd0, 32'h0, 32'h0, 0, dummy);
        bd_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        bit ld, st;
        int sel;
        logic [2:0] f3;
        logic [31:0] a;
        reset = 1'b1;
        in_valid = 0; in_load = 0; in_store = 0; in_funct3 = 0;
        in_address = 0; in_store_data = 0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < MW; i++) setw(i, $urandom);

        // Byte/half extraction and extension.
        setw(1, 32'h80FF_7F01);
        do_req(1, 1, 0, 3'b000, 32'h7, 0, 0, r); chk("LB@7",  r, 32'hFFFF_FF80);
        do_req(1, 1, 0, 3'b100, 32'h7, 0, 0, r); chk("LBU@7", r, 32'h0000_0080);
        do_req(1, 1, 0, 3'b001, 32'h6, 0, 0, r); chk("LH@6",  r, 32'hFFFF_80FF);
        do_req(1, 1, 0, 3'b000, 32'h6, 0, 0, r); chk("LB@6",  r, 32'hFFFF_FFFF);
        do_req(1, 1, 0, 3'b101, 32'h4, 0, 0, r); chk("LHU@4", r, 32'h0000_7F01);

        // Sub-word and word stores, read back with LW.
        setw(2, 32'h1122_3344);
        do_req(1, 0, 1, 3'b000, 32'h9, 32'hAB, 0, r);
        do_req(1, 1, 0, 3'b010, 32'h8, 0, 0, r); chk("SB_readback", r, 32'h1122_AB44);
        setw(3, 32'h0);
        do_req(1, 0, 1, 3'b001, 32'hE, 32'hBEEF, 0, r);
        do_req(1, 1, 0, 3'b010, 32'hC, 0, 0, r); chk("SH_readback", r, 32'hBEEF_0000);
        do_req(1, 0, 1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, r);
        do_req(1, 1, 0, 3'b010, 32'h10, 0, 0, r); chk("SW_readback", r, 32'hDEAD_BEEF);

        // Faulted requests.
        do_req(1, 1, 0, 3'b010, 32'h2, 0, 0, r);
        do_req(1, 1, 0, 3'b001, 32'h3, 0, 0, r);
        do_req(1, 0, 1, 3'b100, 32'h8, 32'h55, 0, r);
        do_req(1, 1, 1, 3'b010, 32'h20, 32'h55, 0, r);
        do_req(1, 1, 0, 3'b010, 32'h100, 0, 0, r);
        do_req(1, 0, 0, 3'b010, 32'h8, 0, 0, r);
        do_req(1, 1, 0, 3'b010, 32'h8, 0, 0, r); chk("fault_no_write", r, 32'h1122_AB44);

        // Reset during the write cycle of an SB.
        setw(5, 32'hCAFE_F00D);
        do_req(1, 0, 1, 3'b000, 32'h15, 32'h99, 1, r);
        do_req(1, 1, 0, 3'b010, 32'h14, 0, 0, r); chk("reset_mid_rmw", r, 32'hCAFE_F00D);

        // Back-to-back SB into one word.
        setw(0, 32'h0);
        do_req(1, 0, 1, 3'b000, 32'h0, 32'h11, 0, r);
        do_req(1, 0, 1, 3'b000, 32'h1, 32'h22, 0, r);
        do_req(1, 1, 0, 3'b010, 32'h0, 0, 0, r); chk("b2b_sb", r, 32'h0000_2211);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 9);
            ld  = (sel == 0) ? 1'b1 : (sel == 1) ? 1'b0 : 1'($urandom);
            st  = (sel == 0) ? 1'b1 : (sel == 1) ? 1'b0 : !ld;
            f3  = ($urandom_range(0, 3) == 0) ? 3'($urandom) :
                  (st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 2)) | 3'({$urandom_range(0, 1), 2'b00}));
            if (f3 == 3'b110) f3 = 3'b010;
            a   = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, MW * 4 - 1));
            do_req($urandom_range(0, 9) != 0, ld, st, f3, a, $urandom, 0, r);
        end

        in_valid = 0;
        clear_exp();
        @(posedge clk); #1;
        for (int i = 0; i < MW; i++) chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
